// File: rtl/sys_ctrl_rx_decoder_if.sv
// Byte-stream / register-file / ALU handshake bundle for the system
// controller receive decoder. The decoder uses the master view; the
// surrounding UART RX, register file and ALU side uses the slave view.
interface sys_ctrl_rx_decoder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] RX_P_DATA;
  logic                  RX_D_VLD;
  logic                  RF_RdData_VLD;
  logic                  ALU_OUT_VLD;
  logic                  RF_WrEn;
  logic                  RF_RdEn;
  logic [ADDR_WIDTH-1:0] RF_Address;
  logic [DATA_WIDTH-1:0] RF_WrData;
  logic                  ALU_EN;
  logic [3:0]            ALU_FUN;
  logic                  CLK_GATE_EN;
  logic                  CMD_DONE;
  logic                  CMD_ERR;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RF_RdData_VLD, ALU_OUT_VLD,
    output RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
           ALU_EN, ALU_FUN, CLK_GATE_EN, CMD_DONE, CMD_ERR
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RF_RdData_VLD, ALU_OUT_VLD,
    input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
           ALU_EN, ALU_FUN, CLK_GATE_EN, CMD_DONE, CMD_ERR
  );
endinterface

// File: rtl/sys_ctrl_rx_decoder.sv
// System controller receive decoder: turns framed UART bytes into
// register-file writes/reads and ALU operation requests.
// Frames: AA addr data | BB addr | CC opa opb fun | DD fun.
// Optional feature macro SYS_CTRL_TIMEOUT_EN: abandons a partial frame
// after TIMEOUT_CYCLES cycles without a byte (wait states never time out).
module sys_ctrl_rx_decoder #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int OPA_ADDR       = 0,
  parameter int OPB_ADDR       = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                  CLK,
  input logic                  RST_n,
  sys_ctrl_rx_decoder_if.master bus
);

  localparam logic [DATA_WIDTH-1:0] OP_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_ALU    = DATA_WIDTH'(8'hDD);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_lat, addr_lat_nxt;
  logic                  wr_en, wr_en_nxt;
  logic                  rd_en, rd_en_nxt;
  logic                  alu_en, alu_en_nxt;
  logic                  gate_en, gate_en_nxt;
  logic                  done, done_nxt;
  logic                  err, err_nxt;
  logic [ADDR_WIDTH-1:0] rf_addr, rf_addr_nxt;
  logic [DATA_WIDTH-1:0] rf_wdata, rf_wdata_nxt;
  logic [3:0]            alu_fun, alu_fun_nxt;
  logic                  tmo_hit;

  logic                  rx_vld;
  logic [DATA_WIDTH-1:0] rx_byte;

  assign rx_vld  = bus.RX_D_VLD;
  assign rx_byte = bus.RX_P_DATA;

`ifdef SYS_CTRL_TIMEOUT_EN
  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             in_frame;

  assign in_frame = (state inside {WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN});
  assign tmo_hit  = in_frame && !rx_vld && (tmo_cnt == TMO_MAX);

  // Inter-byte idle counter: runs only inside a partial frame, restarts on each byte.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      tmo_cnt <= '0;
    end else if (!in_frame || rx_vld || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State and frame-address registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state    <= IDLE;
      addr_lat <= '0;
    end else begin
      state    <= state_nxt;
      addr_lat <= addr_lat_nxt;
    end
  end

  // Output registers: every port is driven straight from a flop.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wr_en    <= 1'b0;
      rd_en    <= 1'b0;
      alu_en   <= 1'b0;
      gate_en  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
      alu_fun  <= '0;
    end else begin
      wr_en    <= wr_en_nxt;
      rd_en    <= rd_en_nxt;
      alu_en   <= alu_en_nxt;
      gate_en  <= gate_en_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      rf_addr  <= rf_addr_nxt;
      rf_wdata <= rf_wdata_nxt;
      alu_fun  <= alu_fun_nxt;
    end
  end

  // Next state and next outputs: strobes default low, levels and data hold.
  always_comb begin
    state_nxt    = state;
    addr_lat_nxt = addr_lat;
    wr_en_nxt    = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    rd_en_nxt    = rd_en;
    alu_en_nxt   = alu_en;
    gate_en_nxt  = gate_en;
    rf_addr_nxt  = rf_addr;
    rf_wdata_nxt = rf_wdata;
    alu_fun_nxt  = alu_fun;

    case (state)
      IDLE: begin
        if (rx_vld) begin
          if (rx_byte == OP_WR)          state_nxt = WR_ADDR;
          else if (rx_byte == OP_RD)     state_nxt = RD_ADDR;
          else if (rx_byte == OP_ALU_OP) state_nxt = OPA;
          else if (rx_byte == OP_ALU)    state_nxt = FUN;
          else                           err_nxt   = 1'b1;
        end
      end
      WR_ADDR: begin
        if (rx_vld) begin
          addr_lat_nxt = rx_byte[ADDR_WIDTH-1:0];
          state_nxt    = WR_DATA;
        end
      end
      WR_DATA: begin
        if (rx_vld) begin
          wr_en_nxt    = 1'b1;
          done_nxt     = 1'b1;
          rf_addr_nxt  = addr_lat;
          rf_wdata_nxt = rx_byte;
          state_nxt    = IDLE;
        end
      end
      RD_ADDR: begin
        if (rx_vld) begin
          rd_en_nxt   = 1'b1;
          rf_addr_nxt = rx_byte[ADDR_WIDTH-1:0];
          state_nxt   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // A byte arriving while waiting is dropped, even alongside completion.
        err_nxt = rx_vld;
        if (bus.RF_RdData_VLD) begin
          rd_en_nxt = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      OPA: begin
        if (rx_vld) begin
          wr_en_nxt    = 1'b1;
          rf_addr_nxt  = ADDR_WIDTH'(OPA_ADDR);
          rf_wdata_nxt = rx_byte;
          state_nxt    = OPB;
        end
      end
      OPB: begin
        if (rx_vld) begin
          wr_en_nxt    = 1'b1;
          rf_addr_nxt  = ADDR_WIDTH'(OPB_ADDR);
          rf_wdata_nxt = rx_byte;
          state_nxt    = FUN;
        end
      end
      FUN: begin
        if (rx_vld) begin
          alu_en_nxt  = 1'b1;
          gate_en_nxt = 1'b1;
          alu_fun_nxt = rx_byte[3:0];
          state_nxt   = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        err_nxt = rx_vld;
        if (bus.ALU_OUT_VLD) begin
          alu_en_nxt  = 1'b0;
          gate_en_nxt = 1'b0;
          done_nxt    = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (tmo_hit) begin
      state_nxt = IDLE;
      err_nxt   = 1'b1;
    end
  end

  assign bus.RF_WrEn     = wr_en;
  assign bus.RF_RdEn     = rd_en;
  assign bus.RF_Address  = rf_addr;
  assign bus.RF_WrData   = rf_wdata;
  assign bus.ALU_EN      = alu_en;
  assign bus.ALU_FUN     = alu_fun;
  assign bus.CLK_GATE_EN = gate_en;
  assign bus.CMD_DONE    = done;
  assign bus.CMD_ERR     = err;

endmodule
